// File: rtl/ovf_counter.sv
// ovf_counter: up/down counter with wrap/saturate, overflow/underflow pulses, sticky flags and event count
module ovf_counter #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               EVT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             flag_clr,
   output logic [WIDTH-1:0] count,
   output logic             ovf_pulse,
   output logic             unf_pulse,
   output logic             ovf_sticky,
   output logic             unf_sticky,
   output logic [EVT_W-1:0] evt_cnt
);
   logic             ovf_evt, unf_evt, evt;
   logic [WIDTH-1:0] count_nxt;
   logic [EVT_W-1:0] evt_nxt;
   // events only come from a counting step at a boundary; load suppresses them
   always_comb begin
      ovf_evt   = !load && en && up && (count == '1);
      unf_evt   = !load && en && !up && (count == '0);
      evt       = ovf_evt || unf_evt;
      count_nxt = load ? load_val :
                  !en ? count :
                  (evt && sat_mode) ? count :
                  up ? count + 1'b1 : count - 1'b1;
      evt_nxt   = flag_clr ? EVT_W'(evt) :
                  (evt && evt_cnt != '1) ? evt_cnt + 1'b1 : evt_cnt;
   end
   // all outputs registered; an event in the clearing cycle survives the clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count      <= RST_VAL;
         ovf_pulse  <= 1'b0;
         unf_pulse  <= 1'b0;
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
         evt_cnt    <= '0;
      end else begin
         count      <= count_nxt;
         ovf_pulse  <= ovf_evt;
         unf_pulse  <= unf_evt;
         ovf_sticky <= ovf_evt || (ovf_sticky && !flag_clr);
         unf_sticky <= unf_evt || (unf_sticky && !flag_clr);
         evt_cnt    <= evt_nxt;
      end
   end
endmodule
